// File: rtl/line_window3.sv
// ============================================================================
// Module   : line_window3
// Purpose  : 3x3 sliding pixel window over a raster stream, two line buffers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module line_window3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [23:0] pix_in,
    input  logic        sof,
    output logic [23:0] x00,
    output logic [23:0] x01,
    output logic [23:0] x02,
    output logic [23:0] x10,
    output logic [23:0] x11,
    output logic [23:0] x12,
    output logic [23:0] x20,
    output logic [23:0] x21,
    output logic [23:0] x22,
    output logic        win_valid,
    output logic [9:0]  win_x,
    output logic [9:0]  win_y
);

    localparam int         c_AW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [9:0] c_XMAX = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] c_YMAX = 10'(IMG_HEIGHT - 1);

    // Counters hold the position the next accepted pixel will take.
    logic [9:0]      r_col;
    logic [9:0]      r_row;
    logic [9:0]      w_col;
    logic [9:0]      w_row;
    logic [c_AW-1:0] w_addr;

    // Line buffer A holds row r-1, B holds row r-2.
    logic [23:0]     r_lb_a [IMG_WIDTH];
    logic [23:0]     r_lb_b [IMG_WIDTH];
    logic [23:0]     r_rd_a;
    logic [23:0]     r_rd_b;

    logic            r_v1;
    logic [23:0]     r_p1;
    logic [9:0]      r_c1;
    logic [9:0]      r_r1;

    always_comb begin
        w_col  = sof ? 10'd0 : r_col;
        w_row  = sof ? 10'd0 : r_row;
        w_addr = w_col[c_AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= 10'd0;
            r_row <= 10'd0;
        end else if (pix_valid) begin
            if (w_col == c_XMAX) begin
                r_col <= 10'd0;
                r_row <= (w_row == c_YMAX) ? 10'd0 : w_row + 10'd1;
            end else begin
                r_col <= w_col + 10'd1;
                r_row <= w_row;
            end
        end
    end

    // B is refilled one cycle later from A's registered read data, giving a
    // line cascade with read-before-write on both buffers.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_rd_a         <= r_lb_a[w_addr];
            r_rd_b         <= r_lb_b[w_addr];
            r_lb_a[w_addr] <= pix_in;
        end
        if (r_v1) begin
            r_lb_b[r_c1[c_AW-1:0]] <= r_rd_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_p1 <= 24'd0;
            r_c1 <= 10'd0;
            r_r1 <= 10'd0;
        end else begin
            r_v1 <= pix_valid;
            if (pix_valid) begin
                r_p1 <= pix_in;
                r_c1 <= w_col;
                r_r1 <= w_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x00       <= 24'd0;
            x01       <= 24'd0;
            x02       <= 24'd0;
            x10       <= 24'd0;
            x11       <= 24'd0;
            x12       <= 24'd0;
            x20       <= 24'd0;
            x21       <= 24'd0;
            x22       <= 24'd0;
            win_valid <= 1'b0;
            win_x     <= 10'd0;
            win_y     <= 10'd0;
        end else begin
            win_valid <= 1'b0;
            if (r_v1) begin
                x00 <= x01;
                x01 <= x02;
                x02 <= r_rd_b;
                x10 <= x11;
                x11 <= x12;
                x12 <= r_rd_a;
                x20 <= x21;
                x21 <= x22;
                x22 <= r_p1;
                // Gating on row/col keeps wrapped columns and stale lines out.
                if ((r_r1 >= 10'd2) && (r_c1 >= 10'd2)) begin
                    win_valid <= 1'b1;
                    win_x     <= r_c1 - 10'd1;
                    win_y     <= r_r1 - 10'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire
